// File: rtl/instr_fetch_unit.sv
// Generic synchronous FIFO; the head entry is read straight out of flop storage.
// Latency: a written entry is visible at the head one cycle after the write.
// Backpressure: none internally; the writer must only write when a slot is free.
module fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   rd_rdy,
    output logic                   rd_vld,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_fire;
    logic [AW:0]      count_nxt;

    assign rd_fire = rd_vld & rd_rdy;
    assign rd_dat  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + (AW+1)'(wr_vld) - (AW+1)'(rd_fire);
        end
    end

    // Storage is cleared on reset so the head reads zero until the first write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_vld <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count  <= count_nxt;
            rd_vld <= (count_nxt != '0);
        end
    end
endmodule

// Instruction fetch: PC, one-outstanding imem requests, buffered {instr, pc} stream to the decoder.
// Latency: zero-wait memory gives instr_valid one cycle after the accepting imem_ready; 1 instr/cycle sustained.
// Backpressure: a request is only issued when its buffer slot is guaranteed; full buffer drops imem_req.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_ent_t;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] target;
    logic        handshake;
    logic        push;
    logic        pop;
    logic        room;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    fetch_ent_t  wr_ent;
    fetch_ent_t  head;

    assign target    = branch_target & 32'hFFFF_FFFC;
    assign handshake = imem_req & imem_ready;
    assign pop       = instr_valid & instr_ready;
    assign push      = handshake & (state == REQ) & ~branch_taken;
    assign wr_ent    = '{instr: imem_rdata, pc: fetch_pc};

    always_comb begin
        count_next = count;
        if (branch_taken) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
        end
    end

    assign room = (count_next < CW'(BUF_DEPTH));

    fifo #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .flush  (branch_taken),
        .wr_vld (push),
        .wr_dat (wr_ent),
        .rd_rdy (instr_ready),
        .rd_vld (instr_valid),
        .rd_dat (head),
        .count  (count)
    );

    assign instr    = head.instr;
    assign instr_pc = head.pc;

    // In DROP, fetch_pc already holds the redirect target while imem_addr keeps the stale address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_taken) begin
                        fetch_pc  <= target;
                        imem_addr <= target;
                        imem_req  <= 1'b1;
                        state     <= REQ;
                    end else if (room) begin
                        imem_req <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (branch_taken) begin
                        fetch_pc <= target;
                        if (imem_ready) begin
                            imem_addr <= target;
                        end else begin
                            state <= DROP;
                        end
                    end else if (imem_ready) begin
                        fetch_pc  <= fetch_pc + 32'd4;
                        imem_addr <= fetch_pc + 32'd4;
                        if (!room) begin
                            imem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (branch_taken) begin
                        fetch_pc <= target;
                    end
                    if (imem_ready) begin
                        imem_addr <= branch_taken ? target : fetch_pc;
                        state     <= REQ;
                    end
                end
                default: begin
                    imem_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scenarios followed by random traffic, all checked against a queue-based stream model.
module tb_instr_fetch_unit;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] q[$];
    logic [31:0] fpc;
    logic [31:0] prev_addr;
    int unsigned epoch;
    int unsigned req_epoch;
    logic        prev_wait;
    logic        after_reset;
    logic        mem_force_ready;
    int          wait_cfg;
    int          wcnt;
    logic [31:0] stream_words [3] = '{32'hE280_0001, 32'hE591_0000, 32'hE581_0000};

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   mem_word = 32'hE280_0001;
            32'h4:   mem_word = 32'hE591_0000;
            32'h8:   mem_word = 32'hE581_0000;
            default: mem_word = {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: act as memory, drive decoder/branch inputs, update the model, then advance.
    task automatic cycle(input logic rdy, input logic br, input logic [31:0] tgt);
        logic        cur_req;
        logic        hs;
        logic        pop;
        logic [31:0] cur_addr;
        cur_req  = imem_req;
        cur_addr = imem_addr;
        hs       = 1'b0;
        if (mem_force_ready) imem_ready = 1'b1;
        else imem_ready = (cur_req === 1'b1) && (wcnt >= wait_cfg);
        imem_rdata    = imem_ready ? mem_word(cur_addr) : 32'hBAD0_BAD0;
        instr_ready   = rdy;
        branch_taken  = br;
        branch_target = tgt;
        if (!reset) begin
            chk("valid_vs_model", 32'(instr_valid), 32'(q.size() != 0));
            if (!after_reset) chk("req_vs_room", 32'(cur_req), 32'(q.size() < BUF_DEPTH));
            if (prev_wait) chk("addr_held", cur_addr, prev_addr);
            if (cur_req && !prev_wait) req_epoch = epoch;
            pop = instr_valid && rdy;
            if (pop && q.size() != 0) begin
                chk("pop_pc", instr_pc, q[0]);
                chk("pop_instr", instr, mem_word(q[0]));
                void'(q.pop_front());
            end
            hs = cur_req && imem_ready;
            if (hs && !br && req_epoch == epoch) begin
                chk("push_addr", cur_addr, fpc);
                q.push_back(fpc);
                fpc = fpc + 32'd4;
            end
            if (br) begin
                q.delete();
                fpc = tgt & 32'hFFFF_FFFC;
                epoch++;
            end
            prev_wait   = cur_req && !imem_ready;
            prev_addr   = cur_addr;
            after_reset = 1'b0;
        end
        if (hs) wcnt = 0;
        else if (cur_req === 1'b1) wcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset           = 1'b1;
        mem_force_ready = 1'b1;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
        reset           = 1'b0;
        mem_force_ready = 1'b0;
        imem_ready      = 1'b0;
        q.delete();
        fpc         = RESET_PC;
        epoch++;
        prev_wait   = 1'b0;
        after_reset = 1'b1;
        wcnt        = 0;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
        epoch = 0; req_epoch = 0; prev_wait = 1'b0; after_reset = 1'b1;
        mem_force_ready = 1'b0; wait_cfg = 0; wcnt = 0; fpc = RESET_PC; prev_addr = '0;

        // Reset with memory claiming ready throughout
        do_reset(3);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);

        // Streaming from zero-wait memory
        cycle(1'b1, 1'b0, 32'h0);
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 32'h0);
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_pc", instr_pc, 32'(k * 4));
            chk("stream_instr", instr, stream_words[k]);
        end

        // Backpressure: fill two entries, then drain one at a time
        do_reset(2);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 32'h0);
        chk("bp_req", 32'(imem_req), 32'd0);
        chk("bp_addr", imem_addr, 32'd8);
        chk("bp_pc", instr_pc, 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("bp_req_again", 32'(imem_req), 32'd1);
        chk("bp_addr_again", imem_addr, 32'd8);
        chk("bp_order1", instr_pc, 32'd4);
        cycle(1'b0, 1'b0, 32'h0);
        chk("bp_refill_req", 32'(imem_req), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("bp_order2", instr_pc, 32'd8);
        cycle(1'b1, 1'b0, 32'h0);

        // Three wait states per request
        do_reset(2);
        wait_cfg = 3;
        cycle(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            chk("ws_addr", imem_addr, 32'd0);
            chk("ws_valid", 32'(instr_valid), 32'd0);
        end
        cycle(1'b0, 1'b0, 32'h0);
        chk("ws_valid_after", 32'(instr_valid), 32'd1);
        chk("ws_pc", instr_pc, 32'd0);
        chk("ws_next_addr", imem_addr, 32'd4);
        cycle(1'b0, 1'b0, 32'h0);

        // Branch while waiting at 4: flush, keep stale address, drop its response
        cycle(1'b0, 1'b1, 32'h0000_0103);
        chk("br_flush", 32'(instr_valid), 32'd0);
        chk("br_req", 32'(imem_req), 32'd1);
        chk("br_stale_addr", imem_addr, 32'd4);
        cycle(1'b0, 1'b0, 32'h0);
        chk("br_stale_addr2", imem_addr, 32'd4);
        cycle(1'b0, 1'b0, 32'h0);
        chk("br_drop_valid", 32'(instr_valid), 32'd0);
        chk("br_target_addr", imem_addr, 32'h100);
        wait_cfg = 0;
        cycle(1'b0, 1'b0, 32'h0);
        chk("br_first_valid", 32'(instr_valid), 32'd1);
        chk("br_first_pc", instr_pc, 32'h100);

        // Branch coincident with imem_ready
        cycle(1'b0, 1'b1, 32'h0000_0200);
        chk("bc_valid", 32'(instr_valid), 32'd0);
        chk("bc_req", 32'(imem_req), 32'd1);
        chk("bc_addr", imem_addr, 32'h200);

        // Reset while a request is waiting
        wait_cfg = 5;
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        do_reset(1);
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, 32'd0);
        chk("mr_valid", 32'(instr_valid), 32'd0);
        chk("mr_instr", instr, 32'd0);
        chk("mr_pc", instr_pc, 32'd0);
        wait_cfg = 0;
        cycle(1'b0, 1'b0, 32'h0);
        chk("mr_req_after", 32'(imem_req), 32'd1);
        chk("mr_no_push", 32'(instr_valid), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("mr_first_instr", instr, 32'hE280_0001);

        // PC wrap-around
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'h0);
        chk("wrap_pc2", instr_pc, 32'h0000_0000);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) wait_cfg = int'($urandom_range(0, 3));
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
            if (i == 2000) do_reset(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
